branch_update_queue: RTL and testbench

//  Producer side of the branch-predictor update interface. Accepts resolved

---
 rtl/branch_update_queue_pkg.sv | 38 +++
 rtl/branch_update_queue_if.sv | 41 ++++
 rtl/branch_update_queue_fifo.sv | 63 ++++++
 rtl/branch_update_queue.sv | 74 +++++++
 tb/tb_branch_update_queue.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/branch_update_queue_pkg.sv
// Shared types for the branch-predictor update path: the queued update entry
// and the 2-bit saturating direction-counter encodings used by the predictor.
package branch_update_queue_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
    } updateEntry_t;

    localparam int ENTRY_W = $bits(updateEntry_t);

    typedef enum logic [1:0] {
        STRONG_NOT_TAKEN = 2'b00,
        WEAK_NOT_TAKEN   = 2'b01,
        WEAK_TAKEN       = 2'b10,
        STRONG_TAKEN     = 2'b11
    } predCounter_t;

    // Predictor-side counter step; kept beside the encodings so both ends agree.
    function automatic predCounter_t predCounterNext(input predCounter_t current,
                                                     input logic         resolvedTaken);
        predCounter_t nextValue;
        nextValue = current;
        if (resolvedTaken && current != STRONG_TAKEN) begin
            nextValue = predCounter_t'(current + 2'd1);
        end else if (!resolvedTaken && current != STRONG_NOT_TAKEN) begin
            nextValue = predCounter_t'(current - 2'd1);
        end
        return nextValue;
    endfunction

    function automatic logic predCounterTaken(input predCounter_t current);
        return current[1];
    endfunction

endpackage

// File: rtl/branch_update_queue_if.sv
// Commit-side and predictor-side handshake bundle of the branch update queue.
// The queue uses the slave view; the surrounding pipeline drives the master view.
interface branch_update_queue_if;
    import branch_update_queue_pkg::*;

    logic            commitValid;
    logic [XLEN-1:0] commitPc;
    logic            commitTaken;
    logic            commitPred;
    logic            commitReady;

    logic            readyIn;
    logic            updateValid;
    logic [XLEN-1:0] updateInstr;
    logic            taken;

    modport slave (
        input  commitValid,
        input  commitPc,
        input  commitTaken,
        input  commitPred,
        input  readyIn,
        output commitReady,
        output updateValid,
        output updateInstr,
        output taken
    );

    modport master (
        output commitValid,
        output commitPc,
        output commitTaken,
        output commitPred,
        output readyIn,
        input  commitReady,
        input  updateValid,
        input  updateInstr,
        input  taken
    );

endinterface

// File: rtl/branch_update_queue_fifo.sv
// Count-based FIFO of resolved-branch entries with a combinational head read.
// Storage is not reset; only pointers and occupancy are.
module branch_update_fifo
    import branch_update_queue_pkg::*;
#(
    parameter int DEPTH_WIDTH = 2
) (
    input  logic         clockIn,
    input  logic         resetIn,
    input  logic         wrEn,
    input  updateEntry_t wrData,
    input  logic         rdEn,
    output updateEntry_t headData,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] COUNT_FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};

    updateEntry_t           mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wrPtr;
    logic [DEPTH_WIDTH-1:0] rdPtr;
    logic [DEPTH_WIDTH:0]   count;
    logic                   wrDo;
    logic                   rdDo;

    assign full  = (count == COUNT_FULL);
    assign empty = (count == '0);

    // Guard locally so a caller bug can never push into a full or pop an empty FIFO.
    assign wrDo = wrEn && !full;
    assign rdDo = rdEn && !empty;

    assign headData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrDo) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (rdDo) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({wrDo, rdDo})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clockIn) begin
        if (wrDo) begin
            mem[wrPtr] <= wrData;
        end
    end

endmodule

// File: rtl/branch_update_queue.sv
// Producer side of the predictor update port: buffers committed conditional
// branches and drains one per ready cycle, with saturating branch/mispredict stats.
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int DEPTH_WIDTH = 2,
    parameter int STAT_WIDTH  = 32
) (
    input  logic                    clockIn,
    input  logic                    resetIn,
    branch_update_queue_if.slave    bus,
    input  logic                    statClear,
    output logic [STAT_WIDTH-1:0]   branchCount,
    output logic [STAT_WIDTH-1:0]   mispredCount
);

    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  enqAccept;
    logic                  deqAccept;
    logic                  isMispred;
    updateEntry_t          enqEntry;
    updateEntry_t          headEntry;
    logic [STAT_WIDTH-1:0] branchCountQ;
    logic [STAT_WIDTH-1:0] mispredCountQ;

    function automatic logic [STAT_WIDTH-1:0] satInc(input logic [STAT_WIDTH-1:0] value);
        return (&value) ? value : value + STAT_WIDTH'(1);
    endfunction

    // commitReady is pure state so the ROB never sees a path from readyIn.
    assign bus.commitReady = !fifoFull;
    assign bus.updateValid = !fifoEmpty;
    assign bus.updateInstr = headEntry.pc;
    assign bus.taken       = headEntry.taken;

    assign enqAccept = bus.commitValid && !fifoFull;
    assign deqAccept = !fifoEmpty && bus.readyIn;
    assign isMispred = (bus.commitPred != bus.commitTaken);
    assign enqEntry  = '{pc: bus.commitPc, taken: bus.commitTaken};

    branch_update_fifo #(
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_fifo (
        .clockIn  (clockIn),
        .resetIn  (resetIn),
        .wrEn     (enqAccept),
        .wrData   (enqEntry),
        .rdEn     (deqAccept),
        .headData (headEntry),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // Clear takes priority over an increment landing on the same edge.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            branchCountQ  <= '0;
            mispredCountQ <= '0;
        end else if (statClear) begin
            branchCountQ  <= '0;
            mispredCountQ <= '0;
        end else if (enqAccept) begin
            branchCountQ <= satInc(branchCountQ);
            if (isMispred) begin
                mispredCountQ <= satInc(mispredCountQ);
            end
        end
    end

    assign branchCount  = branchCountQ;
    assign mispredCount = mispredCountQ;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed scoreboard bench for branch_update_queue: a queue model tracks
// expected entries and statistics, compared every cycle on the falling edge.
module tb_branch_update_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
    } ent_t;

    logic        clockIn;
    logic        resetIn;
    logic        statClear;
    logic [31:0] branchCount;
    logic [31:0] mispredCount;

    int checks = 0;
    int errors = 0;

    ent_t        sbQ[$];
    logic [31:0] expBc;
    logic [31:0] expMc;

    branch_update_queue_if bif();

    branch_update_queue #(
        .DEPTH_WIDTH (2),
        .STAT_WIDTH  (32)
    ) dut (
        .clockIn      (clockIn),
        .resetIn      (resetIn),
        .bus          (bif),
        .statClear    (statClear),
        .branchCount  (branchCount),
        .mispredCount (mispredCount)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compareAll(input string tag);
        ent_t head;
        head = (sbQ.size() != 0) ? sbQ[0] : '0;
        chk({tag, ".updateValid"}, {31'd0, bif.updateValid}, {31'd0, sbQ.size() != 0});
        chk({tag, ".updateInstr"}, bif.updateInstr, head.pc);
        chk({tag, ".taken"}, {31'd0, bif.taken}, {31'd0, head.tk});
        chk({tag, ".commitReady"}, {31'd0, bif.commitReady}, {31'd0, sbQ.size() < 4});
        chk({tag, ".branchCount"}, branchCount, expBc);
        chk({tag, ".mispredCount"}, mispredCount, expMc);
    endtask

    // One clock: check outputs from the previous edge, drive, then advance the model.
    task automatic cyc(input string tag, input logic cv, input logic [31:0] pc,
                       input logic tk, input logic pd, input logic rdy, input logic clr);
        bit enq;
        bit deq;
        @(negedge clockIn);
        compareAll(tag);
        bif.commitValid = cv;
        bif.commitPc    = pc;
        bif.commitTaken = tk;
        bif.commitPred  = pd;
        bif.readyIn     = rdy;
        statClear       = clr;
        enq = cv && (sbQ.size() < 4);
        deq = rdy && (sbQ.size() != 0);
        @(posedge clockIn);
        if (deq) void'(sbQ.pop_front());
        if (enq) sbQ.push_back('{pc: pc, tk: tk});
        if (clr) begin
            expBc = '0;
            expMc = '0;
        end else if (enq) begin
            if (expBc != 32'hFFFF_FFFF) expBc = expBc + 1;
            if (pd != tk && expMc != 32'hFFFF_FFFF) expMc = expMc + 1;
        end
    endtask

    initial begin
        resetIn         = 1'b0;
        statClear       = 1'b0;
        bif.commitValid = 1'b0;
        bif.commitPc    = '0;
        bif.commitTaken = 1'b0;
        bif.commitPred  = 1'b0;
        bif.readyIn     = 1'b0;
        expBc = '0;
        expMc = '0;

        // Test 1: reset state and idle
        #2;
        chk("rst.updateValid", {31'd0, bif.updateValid}, 32'd0);
        chk("rst.updateInstr", bif.updateInstr, 32'd0);
        chk("rst.taken", {31'd0, bif.taken}, 32'd0);
        chk("rst.commitReady", {31'd0, bif.commitReady}, 32'd1);
        @(negedge clockIn);
        @(negedge clockIn);
        resetIn = 1'b1;
        for (int i = 0; i < 10; i++) cyc("idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Test 2: single mispredicted commit with readyIn high
        cyc("t2.commit", 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("t2.visible", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("t2.gone", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Test 3: fill with readyIn low, 5th ignored, then drain in order
        for (int i = 0; i < 4; i++)
            cyc("t3.fill", 1'b1, 32'h200 + 32'(i * 4), 1'(i % 2), 1'b0, 1'b0, 1'b0);
        cyc("t3.full", 1'b1, 32'h2F0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("t3.drain", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Test 4: full queue, commit held while draining; accepted after first pop
        for (int i = 0; i < 4; i++)
            cyc("t4.fill", 1'b1, 32'h300 + 32'(i), 1'(i < 2), 1'b1, 1'b0, 1'b0);
        cyc("t4.hold1", 1'b1, 32'h3F0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("t4.hold2", 1'b1, 32'h3F0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc("t4.drain", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Test 5: saturation, then clear beating a same-cycle increment
        @(posedge clockIn);
        #1;
        force dut.branchCountQ = 32'hFFFF_FFFF;
        #1;
        release dut.branchCountQ;
        expBc = 32'hFFFF_FFFF;
        cyc("t5.sat", 1'b1, 32'h500, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("t5.satmis", 1'b1, 32'h504, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("t5.clear", 1'b1, 32'h508, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc("t5.after", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Test 6: async reset mid-drain with three entries queued
        for (int i = 0; i < 4; i++)
            cyc("t6.fill", 1'b1, 32'h600 + 32'(i * 8), 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("t6.pop", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clockIn);
        chk("t6.queued3", {31'd0, bif.updateValid}, 32'd1);
        #2;
        resetIn = 1'b0;
        #1;
        chk("t6.async.updateValid", {31'd0, bif.updateValid}, 32'd0);
        chk("t6.async.updateInstr", bif.updateInstr, 32'd0);
        chk("t6.async.commitReady", {31'd0, bif.commitReady}, 32'd1);
        chk("t6.async.branchCount", branchCount, 32'd0);
        sbQ.delete();
        expBc = '0;
        expMc = '0;
        @(negedge clockIn);
        resetIn = 1'b1;
        for (int i = 0; i < 3; i++) cyc("t6.post", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("t6.recommit", 1'b1, 32'h700, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("t6.recheck", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clockIn);
        compareAll("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
